// File: rtl/piso_serializer_if.sv
// piso_serializer_if: parallel frame load handshake between a producer and the serializer
interface piso_serializer_if #(parameter int WIDTH = 8);
  logic load_valid;
  logic load_ready;
  logic [WIDTH-1:0] load_data;
  modport master(output load_valid, load_data, input load_ready);
  modport slave(input load_valid, load_data, output load_ready);
endinterface

// File: rtl/piso_serializer.sv
// piso_serializer: loads a parallel frame and shifts it out one bit per shift_en edge
module piso_serializer #(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic clk,
  input  logic reset_n,
  piso_serializer_if.slave ld,
  input  logic shift_en,
  input  logic sdi,
  input  logic abort,
  output logic sdo,
  output logic busy,
  output logic done,
  output logic [CW-1:0] bit_cnt
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state;
  logic [WIDTH-1:0] shreg;
  logic last;
  logic hs;
  assign busy = state == SHIFT;
  assign last = busy && bit_cnt == CW'(1) && shift_en;
  // a new frame may slip in on the edge that consumes the final bit
  assign ld.load_ready = !abort && (state == IDLE || last);
  assign hs = ld.load_valid && ld.load_ready;
  assign sdo = busy ? (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]) : IDLE_LEVEL;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      shreg <= '0;
      bit_cnt <= '0;
      done <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
      shreg <= '0;
      bit_cnt <= '0;
      done <= 1'b0;
    end else begin
      done <= last;
      if (hs) begin
        shreg <= ld.load_data;
        bit_cnt <= CW'(WIDTH);
        state <= SHIFT;
      end else if (busy && shift_en) begin
        shreg <= MSB_FIRST ? {shreg[WIDTH-2:0], sdi} : {sdi, shreg[WIDTH-1:1]};
        bit_cnt <= bit_cnt - CW'(1);
        state <= last ? IDLE : SHIFT;
      end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: table vectors plus scoreboarded serial stream for MSB- and LSB-first instances
module tb_piso_serializer;
  logic clk = 0, reset_n = 0, lv = 0, se = 0, sdi = 1, ab = 0;
  logic [7:0] d = 0;
  logic [7:0] a5 = 8'hA5;
  logic sdo0, busy0, done0, sdo1, busy1, done1;
  logic [3:0] cnt0, cnt1;
  int n_tests = 0, n_fail = 0, dn0 = 0, dn1 = 0;
  logic q0[$];
  logic q1[$];
  typedef struct {
    logic lv; logic [7:0] d; logic se; logic ab;
    logic rdy; logic bsy; logic [3:0] cnt; logic o; logic dn;
  } vec_t;
  vec_t tv[10];
  piso_serializer_if #(.WIDTH(8)) if0();
  piso_serializer_if #(.WIDTH(8)) if1();
  assign if0.load_valid = lv;
  assign if0.load_data = d;
  assign if1.load_valid = lv;
  assign if1.load_data = d;
  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u0 (
    .clk(clk), .reset_n(reset_n), .ld(if0), .shift_en(se), .sdi(sdi), .abort(ab),
    .sdo(sdo0), .busy(busy0), .done(done0), .bit_cnt(cnt0));
  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u1 (
    .clk(clk), .reset_n(reset_n), .ld(if1), .shift_en(se), .sdi(sdi), .abort(ab),
    .sdo(sdo1), .busy(busy1), .done(done1), .bit_cnt(cnt1));
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic push(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      q0.push_back(v[7-i]);
      q1.push_back(v[i]);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // expected bit sits at the queue head for as long as it must be held on sdo
  always @(negedge clk) if (reset_n) begin
    if (busy0) begin
      if (q0.size() == 0) chk("sb0_underrun", q0.size(), 1);
      else begin
        chk("sb0_sdo", sdo0, q0[0]);
        if (se && !ab) void'(q0.pop_front());
      end
    end else chk("idle_sdo0", sdo0, 0);
    if (busy1) begin
      if (q1.size() == 0) chk("sb1_underrun", q1.size(), 1);
      else begin
        chk("sb1_sdo", sdo1, q1[0]);
        if (se && !ab) void'(q1.pop_front());
      end
    end else chk("idle_sdo1", sdo1, 0);
    if (done0) dn0++;
    if (done1) dn1++;
  end

  initial begin
    tv[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 4'd8, 1'b1, 1'b0};
    for (int i = 1; i < 8; i++) tv[i] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 4'(8 - i), a5[7-i], 1'b0};
    tv[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1};
    tv[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
    #2;
    chk("rst_ready", if0.load_ready, 1);
    chk("rst_busy", busy0, 0);
    chk("rst_cnt", cnt0, 0);
    chk("rst_sdo", sdo0, 0);
    chk("rst_done", done0, 0);
    cycles(1);
    reset_n = 1;
    cycles(1);
    for (int i = 0; i < 10; i++) begin
      lv = tv[i].lv; d = tv[i].d; se = tv[i].se; ab = tv[i].ab;
      if (i == 0) push(tv[i].d);
      #1 chk("t_ready", if0.load_ready, tv[i].rdy);
      cycles(1);
      chk("t_busy", busy0, tv[i].bsy);
      chk("t_cnt", cnt0, tv[i].cnt);
      chk("t_sdo", sdo0, tv[i].o);
      chk("t_done", done0, tv[i].dn);
    end
    chk("t_sb_left", q0.size() + q1.size(), 0);

    dn0 = 0; dn1 = 0;
    lv = 1; d = 8'hA5; se = 0; push(8'hA5);
    cycles(1);
    lv = 0;
    for (int i = 0; i < 24; i++) begin
      se = (i % 3 == 2);
      chk("slow_cnt", cnt1, 8 - i / 3);
      cycles(1);
    end
    se = 0;
    cycles(2);
    chk("slow_done", dn1, 1);
    chk("slow_busy", busy1, 0);
    chk("slow_sb_left", q1.size(), 0);

    dn0 = 0; dn1 = 0;
    lv = 1; d = 8'h3C; se = 1; push(8'h3C);
    #1 chk("b2b_ready0", if0.load_ready, 1);
    cycles(1);
    d = 8'hC3; push(8'hC3);
    for (int i = 1; i <= 16; i++) begin
      if (i == 9) lv = 0;
      #1 chk("b2b_ready", if0.load_ready, i == 8 || i == 16);
      cycles(1);
      chk("b2b_busy", busy0, i < 16);
    end
    cycles(1);
    chk("b2b_done", dn0, 2);
    chk("b2b_sb_left", q0.size() + q1.size(), 0);

    dn0 = 0; dn1 = 0;
    lv = 1; d = 8'h5A; se = 1; push(8'h5A);
    cycles(1);
    lv = 0;
    cycles(3);
    chk("mid_cnt5", cnt0, 5);
    lv = 1; d = 8'hFF; push(8'hFF);
    for (int i = 0; i < 5; i++) begin
      #1 chk("mid_ready", if0.load_ready, i == 4);
      cycles(1);
    end
    lv = 0;
    chk("mid_cnt8", cnt0, 8);
    chk("mid_busy", busy0, 1);
    cycles(9);
    chk("mid_done", dn0, 2);
    chk("mid_sb_left", q0.size() + q1.size(), 0);

    dn0 = 0; dn1 = 0;
    lv = 1; d = 8'h96; se = 1; push(8'h96);
    cycles(1);
    lv = 0;
    cycles(4);
    chk("ab_cnt4", cnt0, 4);
    ab = 1; lv = 1; d = 8'h77;
    #1 chk("ab_ready", if0.load_ready, 0);
    cycles(1);
    ab = 0; lv = 0;
    q0.delete(); q1.delete();
    chk("ab_busy", busy0, 0);
    chk("ab_cnt", cnt0, 0);
    chk("ab_sdo", sdo0, 0);
    cycles(3);
    chk("ab_done", dn0 + dn1, 0);
    chk("ab_nocap", busy0 | busy1, 0);

    dn0 = 0; dn1 = 0;
    lv = 1; d = 8'hC6; push(8'hC6);
    cycles(1);
    lv = 0;
    cycles(5);
    chk("rs_cnt3", cnt0, 3);
    #2 reset_n = 0;
    #1;
    chk("rs_busy", busy0, 0);
    chk("rs_cnt", cnt0 | cnt1, 0);
    chk("rs_sdo", sdo0, 0);
    chk("rs_done", done0, 0);
    chk("rs_ready", if0.load_ready, 1);
    q0.delete(); q1.delete();
    cycles(1);
    reset_n = 1;
    chk("rs_idle", busy0, 0);
    lv = 1; d = 8'h81; push(8'h81);
    cycles(1);
    lv = 0;
    cycles(9);
    chk("rs_done_after", dn0 + dn1, 2);
    chk("rs_sb_left", q0.size() + q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
